pes_txc_sched: RTL and testbench



---
 rtl/pes_txc_pkg.sv | 21 ++
 rtl/pes_txc_rr_pick.sv | 37 +++
 rtl/pes_txc_sched.sv | 157 +++++++++++++++
 tb/tb_pes_txc_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pes_txc_pkg.sv
// pes_txc_pkg -- shared types and default widths for the PES->TXC issue path.
//   N_TC_DEF    default number of traffic classes (power of 2, >= 2)
//   WGT_W_DEF   default width of a per-TC DWRR quantum, in segments
//   CRED_W_DEF  default width of the TXC buffer-credit counter
//   tc_idx_t    traffic-class index at the default N_TC
//   sched_state_e  scheduler FSM states
package pes_txc_pkg;

  localparam int N_TC_DEF   = 8;
  localparam int WGT_W_DEF  = 4;
  localparam int CRED_W_DEF = 7;
  localparam int TC_W_DEF   = $clog2(N_TC_DEF);

  typedef logic [TC_W_DEF-1:0] tc_idx_t;

  typedef enum logic {
    INIT,
    RUN
  } sched_state_e;

endpackage

// File: rtl/pes_txc_rr_pick.sv
// pes_txc_rr_pick -- combinational rotate-priority finder.
// Returns the first set bit of req scanning upward from start, wrapping
// modulo N. Shared with TXC-side arbiters.
//   req    request vector, one bit per requester
//   start  index that has the highest priority
//   found  at least one request is set
//   idx    index of the winning request (0 when found=0)
module pes_txc_rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // N is a power of two, so the index addition wraps modulo N for free.
    for (int i = 0; i < N; i++) begin
      cand = start + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pes_txc_sched.sv
// pes_txc_sched -- DWRR egress scheduler on the PES side of PES->TXC.
// Picks a traffic class by deficit weighted round-robin, issues one segment
// per accepted handshake, and gates every issue on a TXC buffer-credit count.
//   clk, rst       core clock, synchronous active-high reset
//   cfg_wgt        per-TC quantum in segments (0 behaves as 1)
//   cfg_init_cred  credits loaded in INIT
//   tc_req         per-TC queue non-empty
//   txc_cred_ret   one TXC buffer returned this cycle
//   sched_vld/tc   registered issue, held stable while sched_rdy=0
//   sched_rdy      TXC accepts the issue
//   cred_cnt       current credit count
//   cred_err       sticky credit overflow/underflow
module pes_txc_sched
  import pes_txc_pkg::*;
#(
  parameter int N_TC   = N_TC_DEF,
  parameter int WGT_W  = WGT_W_DEF,
  parameter int CRED_W = CRED_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_TC-1:0][WGT_W-1:0]      cfg_wgt,
  input  logic [CRED_W-1:0]               cfg_init_cred,
  input  logic [N_TC-1:0]                 tc_req,
  input  logic                            txc_cred_ret,
  output logic                            sched_vld,
  output logic [$clog2(N_TC)-1:0]         sched_tc,
  input  logic                            sched_rdy,
  output logic [CRED_W-1:0]               cred_cnt,
  output logic                            cred_err
);

  localparam int TC_W = $clog2(N_TC);

  sched_state_e      state, state_n;
  logic [TC_W-1:0]   cur, cur_n;          // active TC
  logic [TC_W-1:0]   ptr, ptr_n;          // where the next scan starts
  logic              sel_vld, sel_vld_n;  // cur holds a live selection
  logic [WGT_W-1:0]  deficit, deficit_n;
  logic              vld_n;
  logic [TC_W-1:0]   tc_n;
  logic [CRED_W-1:0] cred_n;
  logic              err_n;

  logic              accept, hold, need_sel;
  logic [WGT_W-1:0]  deficit_eff, pick_wgt, load_def;
  logic [CRED_W-1:0] cred_eff;
  logic              pick_found;
  logic [TC_W-1:0]   pick_idx;

  pes_txc_rr_pick #(.N(N_TC)) u_pick (
    .req   (tc_req),
    .start (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign accept = sched_vld & sched_rdy;
  assign hold   = sched_vld & ~sched_rdy;

  // The next issue is decided on the same edge that retires the current
  // one, so look at deficit and credit as they will be after this accept.
  // Returned credits are deliberately left out: they become usable only
  // once they have landed in cred_cnt.
  assign deficit_eff = accept ? deficit - WGT_W'(1) : deficit;
  assign cred_eff    = accept ? cred_cnt - CRED_W'(1) : cred_cnt;

  assign pick_wgt = cfg_wgt[pick_idx];
  assign load_def = (pick_wgt == '0) ? WGT_W'(1) : pick_wgt;

  // Reselect when nothing is selected, the quantum is spent, or the active
  // queue ran dry -- but never while an issue is stalled on sched_rdy.
  assign need_sel = (state == RUN) && !hold &&
                    (!sel_vld || (deficit_eff == '0) || !tc_req[cur]);

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    ptr_n     = ptr;
    sel_vld_n = sel_vld;
    deficit_n = deficit;
    vld_n     = sched_vld;
    tc_n      = sched_tc;
    cred_n    = cred_cnt;
    err_n     = cred_err;

    case (state)
      INIT: begin
        state_n   = RUN;
        cred_n    = cfg_init_cred;
        cur_n     = '0;
        ptr_n     = '0;
        sel_vld_n = 1'b0;
        deficit_n = '0;
        vld_n     = 1'b0;
        tc_n      = '0;
      end

      RUN: begin
        if (accept && !txc_cred_ret) begin
          if (cred_cnt == '0) err_n = 1'b1;
          else                cred_n = cred_cnt - CRED_W'(1);
        end else if (txc_cred_ret && !accept) begin
          if (cred_cnt == '1) err_n = 1'b1;
          else                cred_n = cred_cnt + CRED_W'(1);
        end

        deficit_n = deficit_eff;

        if (!hold) begin
          vld_n = 1'b0;
          if (need_sel) begin
            // Selection cycle: leftover deficit is dropped either way.
            sel_vld_n = pick_found;
            deficit_n = pick_found ? load_def : '0;
            if (pick_found) begin
              cur_n = pick_idx;
              ptr_n = pick_idx + TC_W'(1);
            end
          end else if (cred_eff != '0) begin
            vld_n = 1'b1;
            tc_n  = cur;
          end
        end
      end

      default: state_n = INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // flop samples the values from before this edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cur       <= '0;
      ptr       <= '0;
      sel_vld   <= 1'b0;
      deficit   <= '0;
      sched_vld <= 1'b0;
      sched_tc  <= '0;
      cred_cnt  <= '0;
      cred_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      ptr       <= ptr_n;
      sel_vld   <= sel_vld_n;
      deficit   <= deficit_n;
      sched_vld <= vld_n;
      sched_tc  <= tc_n;
      cred_cnt  <= cred_n;
      cred_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_pes_txc_sched.sv
// tb_pes_txc_sched -- directed bench for pes_txc_sched with a scoreboard.
// Stimulus pushes the expected accepted issues (TC and the number of idle
// cycles before it) into a queue; a negedge monitor pops and compares on
// every accepted handshake. Cycle-level state is checked inline.
module tb_pes_txc_sched;

  logic             clk;
  logic             rst;
  logic [7:0][3:0]  cfg_wgt;
  logic [6:0]       cfg_init_cred;
  logic [7:0]       tc_req;
  logic             txc_cred_ret;
  logic             sched_vld;
  logic [2:0]       sched_tc;
  logic             sched_rdy;
  logic [6:0]       cred_cnt;
  logic             cred_err;

  pes_txc_sched dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wgt       (cfg_wgt),
    .cfg_init_cred (cfg_init_cred),
    .tc_req        (tc_req),
    .txc_cred_ret  (txc_cred_ret),
    .sched_vld     (sched_vld),
    .sched_tc      (sched_tc),
    .sched_rdy     (sched_rdy),
    .cred_cnt      (cred_cnt),
    .cred_err      (cred_err)
  );

  typedef struct {
    int tc;
    int gap;   // idle cycles since the previous accept, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   idle   = 0;
  int   n_iss  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int tc, input int gap);
    exp_t x;
    x.tc  = tc;
    x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic do_reset(input int init);
    rst = 1'b1;
    cfg_init_cred = 7'(init);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("reset_reload_cred", int'(cred_cnt), init);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: an accept happens on the next posedge whenever
  // vld and rdy are both high here, unless reset is about to drop it.
  always @(negedge clk) begin
    if (!rst && sched_vld && sched_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got tc %0d, expected no issue", sched_tc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("issue%0d_tc", n_iss), int'(sched_tc), e.tc);
        if (e.gap >= 0)
          check($sformatf("issue%0d_gap", n_iss), idle, e.gap);
      end
      n_iss++;
      idle = 0;
    end else begin
      idle++;
    end
  end

  initial begin
    rst           = 1'b1;
    cfg_wgt       = '0;
    cfg_init_cred = '0;
    tc_req        = '0;
    txc_cred_ret  = 1'b0;
    sched_rdy     = 1'b0;
    tick(2);

    // Reset state
    check("rst_vld",  int'(sched_vld), 0);
    check("rst_tc",   int'(sched_tc),  0);
    check("rst_cred", int'(cred_cnt),  0);
    check("rst_err",  int'(cred_err),  0);

    // Init and credit exhaustion: 4 credits, TC0 only
    cfg_init_cred = 7'd4;
    cfg_wgt[0]    = 4'd15;
    sched_rdy     = 1'b1;
    rst           = 1'b0;
    check("init_cred_zero", int'(cred_cnt), 0);
    tick(1);
    check("run_cred", int'(cred_cnt), 4);
    push(0, -1); push(0, 0); push(0, 0); push(0, 0);
    tc_req = 8'h01;
    tick(1);
    check("latency_sel_cycle_vld", int'(sched_vld), 0);
    tick(1);
    check("latency_first_vld", int'(sched_vld), 1);
    check("latency_first_tc",  int'(sched_tc),  0);
    tick(6);
    check("exhaust_vld",  int'(sched_vld), 0);
    check("exhaust_cred", int'(cred_cnt),  0);
    drain("exhaust_drain");
    push(0, -1);
    txc_cred_ret = 1'b1;
    tick(1);
    txc_cred_ret = 1'b0;
    check("ret_cred", int'(cred_cnt), 1);
    check("ret_vld_not_yet", int'(sched_vld), 0);
    tick(1);
    check("ret_issue_vld", int'(sched_vld), 1);
    tick(1);
    check("ret_issue_cred", int'(cred_cnt), 0);
    check("ret_issue_vld_off", int'(sched_vld), 0);
    tc_req = 8'h00;
    drain("ret_drain");
    tick(2);

    // Backpressure
    do_reset(20);
    sched_rdy = 1'b0;
    push(0, -1);
    tc_req = 8'h01;
    tick(2);
    tc_req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("bp%0d_vld", i),  int'(sched_vld), 1);
      check($sformatf("bp%0d_tc", i),   int'(sched_tc),  0);
      check($sformatf("bp%0d_cred", i), int'(cred_cnt),  20);
    end
    sched_rdy = 1'b1;
    tick(1);
    check("bp_accept_cred", int'(cred_cnt), 19);
    check("bp_accept_vld",  int'(sched_vld), 0);
    drain("bp_drain");

    // Simultaneous accept and return
    do_reset(10);
    push(0, -1);
    tc_req = 8'h01;
    tick(2);
    check("simul_pre_vld",  int'(sched_vld), 1);
    check("simul_pre_cred", int'(cred_cnt),  10);
    txc_cred_ret = 1'b1;
    tc_req = 8'h00;
    tick(1);
    txc_cred_ret = 1'b0;
    check("simul_cred", int'(cred_cnt), 10);
    drain("simul_drain");

    // Saturation at 127
    do_reset(127);
    txc_cred_ret = 1'b1;
    tick(1);
    txc_cred_ret = 1'b0;
    check("sat_cred", int'(cred_cnt), 127);
    check("sat_err",  int'(cred_err), 1);
    tick(3);
    check("sat_err_sticky", int'(cred_err), 1);
    rst = 1'b1;
    tick(1);
    check("sat_err_cleared", int'(cred_err), 0);

    // DWRR ratio: TC0 quantum 3, TC1 quantum 1
    cfg_wgt = '0;
    cfg_wgt[0] = 4'd3;
    cfg_wgt[1] = 4'd1;
    do_reset(64);
    push(0, -1); push(0, 0); push(0, 0); push(1, 1);
    push(0, 1);  push(0, 0); push(0, 0); push(1, 1);
    push(0, 1);  push(0, 0); push(0, 0); push(1, 1);
    tc_req = 8'h03;
    tick(19);
    tc_req = 8'h00;
    drain("dwrr_drain");
    tick(2);
    check("dwrr_cred", int'(cred_cnt), 52);
    check("dwrr_idle_vld", int'(sched_vld), 0);

    // Wrap from TC7 to TC0 with zero weight on TC0
    cfg_wgt = '0;
    cfg_wgt[7] = 4'd2;
    do_reset(64);
    push(7, -1); push(7, 0); push(0, 1); push(7, 1); push(7, 0);
    tc_req = 8'h80;
    tick(1);
    tc_req = 8'h81;
    tick(7);
    tc_req = 8'h00;
    drain("wrap_drain");
    tick(2);
    check("wrap_cred", int'(cred_cnt), 59);

    // Mid-operation reset: TC5 streaming, then reset restarts scan at TC0
    cfg_wgt = '0;
    cfg_wgt[2] = 4'd15;
    cfg_wgt[5] = 4'd15;
    do_reset(64);
    push(5, -1); push(5, 0);
    tc_req = 8'h20;
    tick(1);
    tc_req = 8'h24;
    tick(3);
    check("mid_pre_vld", int'(sched_vld), 1);
    check("mid_pre_tc",  int'(sched_tc),  5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_vld",  int'(sched_vld), 0);
    check("mid_rst_cred", int'(cred_cnt),  0);
    check("mid_rst_q",    exp_q.size(),    0);
    push(2, -1);
    tick(1);
    check("mid_init_cred", int'(cred_cnt),  64);
    check("mid_init_vld",  int'(sched_vld), 0);
    tick(2);
    check("mid_first_vld", int'(sched_vld), 1);
    check("mid_first_tc",  int'(sched_tc),  2);
    tc_req = 8'h00;
    drain("mid_drain");
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
